// File: rtl/alu_rs_scheduler_if.sv
// Bundle of dispatch, CDB and issue signals between the ALU reservation station
// and its neighbours. The RS takes the slave modport.
interface alu_rs_scheduler_if #(
  parameter int DEPTH         = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int PAYLOAD_WIDTH = 64
);
  localparam int IW = $clog2(DEPTH);

  logic                          flush;
  logic                          rs_ready;
  logic [IW-1:0]                 rs_index;
  logic [IW:0]                   occupancy;

  logic                          disp_valid;
  logic [IW-1:0]                 disp_index;
  logic [TAG_WIDTH-1:0]          disp_reorder;
  logic [1:0][31:0]              disp_operand;
  logic [1:0]                    disp_operand_ready;
  logic [1:0][TAG_WIDTH-1:0]     disp_operand_addr;
  logic [PAYLOAD_WIDTH-1:0]      disp_payload;

  logic [1:0]                    cdb_valid;
  logic [1:0][TAG_WIDTH-1:0]     cdb_reorder;
  logic [1:0][31:0]              cdb_data;

  // issue_valid/issue_ready: a transfer happens on an edge where both are high;
  // while issue_valid && !issue_ready every issue_* field is held stable.
  logic                          issue_valid;
  logic                          issue_ready;
  logic [1:0][31:0]              issue_operand;
  logic [TAG_WIDTH-1:0]          issue_reorder;
  logic [PAYLOAD_WIDTH-1:0]      issue_payload;

  modport master (
    output flush, disp_valid, disp_index, disp_reorder, disp_operand,
           disp_operand_ready, disp_operand_addr, disp_payload,
           cdb_valid, cdb_reorder, cdb_data, issue_ready,
    input  rs_ready, rs_index, occupancy,
           issue_valid, issue_operand, issue_reorder, issue_payload
  );

  modport slave (
    input  flush, disp_valid, disp_index, disp_reorder, disp_operand,
           disp_operand_ready, disp_operand_addr, disp_payload,
           cdb_valid, cdb_reorder, cdb_data, issue_ready,
    output rs_ready, rs_index, occupancy,
           issue_valid, issue_operand, issue_reorder, issue_payload
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops, snoops the CDB for operands and
// issues the oldest fully-ready entry into a registered valid/ready slot.
module alu_rs_scheduler #(
  parameter int DEPTH         = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int PAYLOAD_WIDTH = 64
) (
  input logic               clk,
  input logic               rst,
  alu_rs_scheduler_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]                     busy_q, busy_d;
  // age_q[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0][DEPTH-1:0]          age_q, age_d;
  logic [DEPTH-1:0][TAG_WIDTH-1:0]      reorder_q, reorder_d;
  logic [DEPTH-1:0][1:0][31:0]          opnd_q, opnd_d;
  logic [DEPTH-1:0][1:0]                rdy_q, rdy_d;
  logic [DEPTH-1:0][1:0][TAG_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][PAYLOAD_WIDTH-1:0]  payload_q, payload_d;

  logic                                 issue_valid_q, issue_valid_d;
  logic [1:0][31:0]                     issue_operand_q, issue_operand_d;
  logic [TAG_WIDTH-1:0]                 issue_reorder_q, issue_reorder_d;
  logic [PAYLOAD_WIDTH-1:0]             issue_payload_q, issue_payload_d;
  logic [IW:0]                          occupancy_q, occupancy_d;

  logic [DEPTH-1:0] cand, grant;
  logic [IW-1:0]    sel, free_idx;
  logic             cand_any, disp_we, slot_load;

  always_comb begin : select_logic
    cand     = '0;
    grant    = '0;
    sel      = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) cand[i] = busy_q[i] & rdy_q[i][0] & rdy_q[i][1];
    for (int i = 0; i < DEPTH; i++) grant[i] = cand[i] && ((age_q[i] & cand) == '0);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (grant[i])   sel      = IW'(i);
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  assign cand_any  = |cand;
  assign disp_we   = bus.disp_valid && !bus.flush;
  assign slot_load = (!issue_valid_q || bus.issue_ready) && cand_any && !bus.flush;

  always_comb begin : entry_next
    busy_d    = busy_q;
    age_d     = age_q;
    reorder_d = reorder_q;
    opnd_d    = opnd_q;
    rdy_d     = rdy_q;
    addr_d    = addr_q;
    payload_d = payload_q;

    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (busy_q[i] && !rdy_q[i][k]) begin
          if (bus.cdb_valid[0] && bus.cdb_reorder[0] == addr_q[i][k]) begin
            opnd_d[i][k] = bus.cdb_data[0];
            rdy_d[i][k]  = 1'b1;
          end else if (bus.cdb_valid[1] && bus.cdb_reorder[1] == addr_q[i][k]) begin
            opnd_d[i][k] = bus.cdb_data[1];
            rdy_d[i][k]  = 1'b1;
          end
        end
      end
    end

    if (slot_load) busy_d[sel] = 1'b0;

    if (disp_we) begin
      busy_d[bus.disp_index]    = 1'b1;
      reorder_d[bus.disp_index] = bus.disp_reorder;
      payload_d[bus.disp_index] = bus.disp_payload;
      addr_d[bus.disp_index]    = bus.disp_operand_addr;
      for (int k = 0; k < 2; k++) begin
        opnd_d[bus.disp_index][k] = bus.disp_operand[k];
        rdy_d[bus.disp_index][k]  = bus.disp_operand_ready[k];
        // A broadcast in the dispatch cycle would otherwise be missed forever
        if (!bus.disp_operand_ready[k]) begin
          if (bus.cdb_valid[0] && bus.cdb_reorder[0] == bus.disp_operand_addr[k]) begin
            opnd_d[bus.disp_index][k] = bus.cdb_data[0];
            rdy_d[bus.disp_index][k]  = 1'b1;
          end else if (bus.cdb_valid[1] && bus.cdb_reorder[1] == bus.disp_operand_addr[k]) begin
            opnd_d[bus.disp_index][k] = bus.cdb_data[1];
            rdy_d[bus.disp_index][k]  = 1'b1;
          end
        end
      end
      age_d[bus.disp_index] = busy_q;
      for (int j = 0; j < DEPTH; j++) age_d[j][bus.disp_index] = 1'b0;
    end

    if (bus.flush) begin
      busy_d = '0;
      age_d  = '0;
    end
  end

  always_comb begin : slot_next
    issue_valid_d   = issue_valid_q;
    issue_operand_d = issue_operand_q;
    issue_reorder_d = issue_reorder_q;
    issue_payload_d = issue_payload_q;
    occupancy_d     = occupancy_q + (IW+1)'(disp_we) - (IW+1)'(slot_load);
    if (bus.flush) begin
      issue_valid_d = 1'b0;
      occupancy_d   = '0;
    end else if (slot_load) begin
      issue_valid_d   = 1'b1;
      issue_operand_d = opnd_q[sel];
      issue_reorder_d = reorder_q[sel];
      issue_payload_d = payload_q[sel];
    end else if (issue_valid_q && bus.issue_ready) begin
      issue_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q          <= '0;
      age_q           <= '0;
      reorder_q       <= '0;
      opnd_q          <= '0;
      rdy_q           <= '0;
      addr_q          <= '0;
      payload_q       <= '0;
      issue_valid_q   <= 1'b0;
      issue_operand_q <= '0;
      issue_reorder_q <= '0;
      issue_payload_q <= '0;
      occupancy_q     <= '0;
    end else begin
      busy_q          <= busy_d;
      age_q           <= age_d;
      reorder_q       <= reorder_d;
      opnd_q          <= opnd_d;
      rdy_q           <= rdy_d;
      addr_q          <= addr_d;
      payload_q       <= payload_d;
      issue_valid_q   <= issue_valid_d;
      issue_operand_q <= issue_operand_d;
      issue_reorder_q <= issue_reorder_d;
      issue_payload_q <= issue_payload_d;
      occupancy_q     <= occupancy_d;
    end
  end

  assign bus.rs_ready      = ~&busy_q;
  assign bus.rs_index      = free_idx;
  assign bus.occupancy     = occupancy_q;
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_operand = issue_operand_q;
  assign bus.issue_reorder = issue_reorder_q;
  assign bus.issue_payload = issue_payload_q;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: reset, issue latency, age order, wakeup,
// backpressure/full, flush and asynchronous reset.
module tb_alu_rs_scheduler;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int PW    = 64;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_rs_scheduler_if #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) bus ();

  alu_rs_scheduler #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // writing into a busy entry is illegal
  always @(posedge clk) begin
    if (rst && bus.disp_valid && !bus.flush) begin
      total++;
      if (dut.busy_q[bus.disp_index] !== 1'b0) begin
        bad++;
        $display("FAIL disp_to_busy index=%0d busy=%0b required_busy=0", bus.disp_index, dut.busy_q);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush              = 1'b0;
    bus.disp_valid         = 1'b0;
    bus.disp_index         = '0;
    bus.disp_reorder       = '0;
    bus.disp_operand       = '0;
    bus.disp_operand_ready = '0;
    bus.disp_operand_addr  = '0;
    bus.disp_payload       = '0;
    bus.cdb_valid          = '0;
    bus.cdb_reorder        = '0;
    bus.cdb_data           = '0;
  endtask

  task automatic dispatch(input logic [1:0] idx, input logic [TW-1:0] tag,
                          input logic [31:0] op0, input logic [31:0] op1,
                          input logic [1:0] rdy, input logic [TW-1:0] a0,
                          input logic [TW-1:0] a1, input logic [PW-1:0] pl);
    bus.disp_valid           = 1'b1;
    bus.disp_index           = idx;
    bus.disp_reorder         = tag;
    bus.disp_operand[0]      = op0;
    bus.disp_operand[1]      = op1;
    bus.disp_operand_ready   = rdy;
    bus.disp_operand_addr[0] = a0;
    bus.disp_operand_addr[1] = a1;
    bus.disp_payload         = pl;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    total++; if (bus.rs_ready !== 1'b1) begin bad++; $display("FAIL reset_rs_ready got=%0b exp=1", bus.rs_ready); end
    total++; if (bus.rs_index !== 2'd0) begin bad++; $display("FAIL reset_rs_index got=%0d exp=0", bus.rs_index); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", bus.occupancy); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%0b exp=0", bus.issue_valid); end
    total++; if (bus.issue_reorder !== 4'd0 || bus.issue_payload !== 64'd0 || bus.issue_operand !== 64'd0) begin
      bad++; $display("FAIL reset_issue_fields got=%h/%h/%h exp=0", bus.issue_reorder, bus.issue_payload, bus.issue_operand);
    end
  endtask

  task automatic test_basic();
    bus.issue_ready = 1'b1;
    dispatch(2'd0, 4'd5, 32'h11, 32'h22, 2'b11, 4'd0, 4'd0, 64'hDEAD_BEEF_0000_0005);
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL basic_occ_c got=%0d exp=0", bus.occupancy); end
    tick();
    idle();
    total++; if (bus.occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ_c1 got=%0d exp=1", bus.occupancy); end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_c1 got=%0b exp=0", bus.issue_valid); end
    tick();
    total++; if (bus.issue_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_c2 got=%0b exp=1", bus.issue_valid); end
    total++; if (bus.issue_reorder !== 4'd5) begin bad++; $display("FAIL basic_reorder got=%0d exp=5", bus.issue_reorder); end
    total++; if (bus.issue_operand[0] !== 32'h11 || bus.issue_operand[1] !== 32'h22) begin
      bad++; $display("FAIL basic_operand got=%h,%h exp=11,22", bus.issue_operand[0], bus.issue_operand[1]);
    end
    total++; if (bus.issue_payload !== 64'hDEAD_BEEF_0000_0005) begin bad++; $display("FAIL basic_payload got=%h exp=deadbeef00000005", bus.issue_payload); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL basic_occ_c2 got=%0d exp=0", bus.occupancy); end
    tick();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0b exp=0", bus.issue_valid); end
  endtask

  task automatic test_age_order();
    bus.issue_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      total++; if (bus.rs_index !== 2'(t)) begin bad++; $display("FAIL age_rs_index got=%0d exp=%0d", bus.rs_index, t); end
      dispatch(2'(t), 4'(t + 1), 32'd0, 32'(t), 2'b10, 4'd9, 4'd0, 64'(t));
      tick();
    end
    idle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL age_waiting got=%0b exp=0", bus.issue_valid); end
    bus.cdb_valid      = 2'b01;
    bus.cdb_reorder[0] = 4'd9;
    bus.cdb_data[0]    = 32'hAB;
    tick();
    idle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL age_wake_c1 got=%0b exp=0", bus.issue_valid); end
    tick();
    for (int t = 0; t < 3; t++) begin
      total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'(t + 1)) begin
        bad++; $display("FAIL age_issue_order valid=%0b got=%0d exp=%0d", bus.issue_valid, bus.issue_reorder, t + 1);
      end
      total++; if (bus.issue_operand[0] !== 32'hAB) begin bad++; $display("FAIL age_operand got=%h exp=ab", bus.issue_operand[0]); end
      tick();
    end
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL age_drain got=%0b exp=0", bus.issue_valid); end
  endtask

  task automatic test_same_cycle_wakeup();
    bus.issue_ready = 1'b1;
    dispatch(2'd0, 4'd6, 32'h33, 32'd0, 2'b01, 4'd0, 4'd7, 64'd6);
    bus.cdb_valid      = 2'b11;
    bus.cdb_reorder[0] = 4'd3;
    bus.cdb_data[0]    = 32'h99;
    bus.cdb_reorder[1] = 4'd7;
    bus.cdb_data[1]    = 32'h55;
    tick();
    idle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL same_c1 got=%0b exp=0", bus.issue_valid); end
    tick();
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'd6) begin
      bad++; $display("FAIL same_issue valid=%0b reorder=%0d exp=1/6", bus.issue_valid, bus.issue_reorder);
    end
    total++; if (bus.issue_operand[1] !== 32'h55 || bus.issue_operand[0] !== 32'h33) begin
      bad++; $display("FAIL same_operand got=%h,%h exp=33,55", bus.issue_operand[0], bus.issue_operand[1]);
    end
    tick();
  endtask

  task automatic test_cdb_priority();
    bus.issue_ready = 1'b1;
    dispatch(2'd0, 4'd8, 32'd0, 32'h44, 2'b10, 4'd4, 4'd0, 64'd8);
    tick();
    idle();
    bus.cdb_valid      = 2'b11;
    bus.cdb_reorder[0] = 4'd4;
    bus.cdb_data[0]    = 32'h100;
    bus.cdb_reorder[1] = 4'd4;
    bus.cdb_data[1]    = 32'h200;
    tick();
    idle();
    tick();
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_operand[0] !== 32'h100) begin
      bad++; $display("FAIL prio_port0 valid=%0b got=%h exp=100", bus.issue_valid, bus.issue_operand[0]);
    end
    tick();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL prio_drain got=%0b exp=0", bus.issue_valid); end
  endtask

  task automatic test_backpressure_full();
    logic [1:0] exp_idx [5];
    exp_idx = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
    bus.issue_ready = 1'b0;
    for (int t = 0; t < DEPTH + 1; t++) begin
      total++; if (bus.rs_ready !== 1'b1 || bus.rs_index !== exp_idx[t]) begin
        bad++; $display("FAIL bp_alloc t=%0d ready=%0b index=%0d exp=1/%0d", t, bus.rs_ready, bus.rs_index, exp_idx[t]);
      end
      if (t >= 2) begin
        total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'h0) begin
          bad++; $display("FAIL bp_slot_hold t=%0d valid=%0b reorder=%0d exp=1/0", t, bus.issue_valid, bus.issue_reorder);
        end
      end
      dispatch(exp_idx[t], 4'(t), 32'(t), 32'd0, 2'b11, 4'd0, 4'd0, 64'(t));
      tick();
    end
    idle();
    total++; if (bus.rs_ready !== 1'b0 || bus.rs_index !== 2'd0) begin
      bad++; $display("FAIL bp_full ready=%0b index=%0d exp=0/0", bus.rs_ready, bus.rs_index);
    end
    total++; if (bus.occupancy !== 3'd4) begin bad++; $display("FAIL bp_occ_full got=%0d exp=4", bus.occupancy); end
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'd0 || bus.issue_operand[0] !== 32'd0) begin
      bad++; $display("FAIL bp_slot_stable valid=%0b reorder=%0d exp=1/0", bus.issue_valid, bus.issue_reorder);
    end
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    total++; if (bus.issue_reorder !== 4'd1 || bus.issue_operand[0] !== 32'd1) begin
      bad++; $display("FAIL bp_one_issue reorder=%0d exp=1", bus.issue_reorder);
    end
    total++; if (bus.rs_ready !== 1'b1 || bus.rs_index !== 2'd1) begin
      bad++; $display("FAIL bp_freed ready=%0b index=%0d exp=1/1", bus.rs_ready, bus.rs_index);
    end
    total++; if (bus.occupancy !== 3'd3) begin bad++; $display("FAIL bp_occ_after got=%0d exp=3", bus.occupancy); end
    tick();
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'd1) begin
      bad++; $display("FAIL bp_only_one valid=%0b reorder=%0d exp=1/1", bus.issue_valid, bus.issue_reorder);
    end
  endtask

  task automatic test_flush();
    bus.issue_ready = 1'b1;
    dispatch(2'd1, 4'hF, 32'hF, 32'hF, 2'b11, 4'd0, 4'd0, 64'hF);
    bus.flush = 1'b1;
    tick();
    idle();
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", bus.issue_valid); end
    total++; if (bus.occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", bus.occupancy); end
    total++; if (bus.rs_index !== 2'd0 || bus.rs_ready !== 1'b1) begin
      bad++; $display("FAIL flush_free ready=%0b index=%0d exp=1/0", bus.rs_ready, bus.rs_index);
    end
    tick();
    tick();
    total++; if (bus.issue_valid !== 1'b0 || bus.occupancy !== 3'd0) begin
      bad++; $display("FAIL flush_drop valid=%0b occ=%0d exp=0/0", bus.issue_valid, bus.occupancy);
    end
  endtask

  task automatic test_async_reset();
    bus.issue_ready = 1'b0;
    dispatch(2'd0, 4'hC, 32'h77, 32'h88, 2'b11, 4'd0, 4'd0, 64'hC);
    tick();
    idle();
    tick();
    total++; if (bus.issue_valid !== 1'b1 || bus.issue_reorder !== 4'hC) begin
      bad++; $display("FAIL areset_pre valid=%0b reorder=%0d exp=1/12", bus.issue_valid, bus.issue_reorder);
    end
    #2 rst = 1'b0;
    #1;
    total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%0b exp=0", bus.issue_valid); end
    total++; if (bus.issue_reorder !== 4'd0 || bus.issue_operand !== 64'd0 || bus.occupancy !== 3'd0 || bus.rs_ready !== 1'b1) begin
      bad++; $display("FAIL areset_fields reorder=%0d occ=%0d ready=%0b exp=0/0/1", bus.issue_reorder, bus.occupancy, bus.rs_ready);
    end
    #4 rst = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_age_order();
    test_same_cycle_wakeup();
    test_cdb_priority();
    test_backpressure_full();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation-station storage and issue scheduler for the ALU functional unit in the out-of-order core. It accepts instructions from the dispatcher, tracks operand readiness by snooping the common data bus (CDB), and selects the oldest fully-ready entry. The selected entry goes into a registered issue slot with a valid/ready handshake toward the ALU. It also publishes the free-slot index and ready signal that the dispatcher consumes.

## Interface

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- TAG_WIDTH, 4: ROB index width.
- PAYLOAD_WIDTH, 64: opaque decoded-op bits, carried unchanged to issue.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset; asynchronous and active-low.
- flush  in  1  pipeline flush; clears all entries and the issue slot.
- rs_ready  out  1  at least one entry is free.
- rs_index  out  $clog2(DEPTH)  lowest-numbered free entry; 0 when full.
- occupancy  out  $clog2(DEPTH)+1  number of busy entries.
- disp_valid  in  1  dispatcher writes an entry this cycle.
- disp_index  in  $clog2(DEPTH)  target entry; it equals the rs_index sampled this cycle.
- disp_reorder  in  TAG_WIDTH  ROB index of the instruction.
- disp_operand  in  2x32  operand values.
- disp_operand_ready  in  2  per-operand valid flag.
- disp_operand_addr  in  2xTAG_WIDTH  producer ROB tag, used when not ready.
- disp_payload  in  PAYLOAD_WIDTH  decoded instruction bits.
- cdb_valid  in  2  CDB broadcast valid, one bit per port.
- cdb_reorder  in  2xTAG_WIDTH  broadcast tag.
- cdb_data  in  2x32  broadcast value.
- issue_valid  out  1  issue slot holds an instruction.
- issue_ready  in  1  ALU accepts the slot this cycle.
- issue_operand  out  2x32  operands.
- issue_reorder  out  TAG_WIDTH  ROB index.
- issue_payload  out  PAYLOAD_WIDTH  decoded bits.

## Operation

- Each entry holds: busy, the full disp_* field set, and an age vector of DEPTH bits.
- **Dispatch:** when disp_valid && !flush, the entry at disp_index is loaded at the edge and busy is set.
  - The new entry is marked younger than every currently busy entry: set its row bits for all busy entries, and clear the column bit that older entries hold toward it.
  - Writing to a busy entry is illegal. The bench asserts that this never happens.
- **Wakeup:** every cycle, each busy entry compares each non-ready operand's addr against both CDB ports. On a match it captures cdb_data and sets ready.
  - If both ports match, port 0 wins.
  - Wakeup also applies to the dispatching entry in the same cycle, so a CDB value arriving alongside disp_valid is captured rather than lost.
- **Candidate:** an entry is a candidate when it is busy and both operands are ready in registered state. A wakeup in cycle c makes the entry a candidate in cycle c+1.
- **Select:** pick the candidate with no older candidate, as given by the age vectors.
- **Issue slot load:** the slot loads when (!issue_valid || issue_ready) && a candidate exists && !flush.
  - The selected entry's fields are copied into the slot, and the entry's busy bit is cleared at the same edge.
- **Slot drain:** if issue_valid && issue_ready and there is no candidate, issue_valid deasserts at the next edge.
- **Slot hold:** while issue_valid && !issue_ready, the slot holds and is stable. Selected entries stay in storage and continue to snoop the CDB.
- **Free signals:** rs_ready and rs_index are combinational from registered busy bits. An entry freed at edge e reads as free starting in the cycle after e, so no slot is double-allocated.
- **occupancy** is registered and updated on every edge: +1 on dispatch, −1 on slot load, net 0 when both occur.
- **Flush:** at the next edge, all busy bits, all age bits, issue_valid and occupancy become 0. Dispatch, CDB and slot load are ignored in the flush cycle.

## Timing

- **Reset values:** all busy bits 0, age 0, issue_valid 0, issue_operand/issue_reorder/issue_payload 0, occupancy 0. Therefore rs_ready = 1 and rs_index = 0 out of reset.
- **Dispatch-to-issue latency**, with both operands ready at dispatch and an empty slot:
  - disp_valid in cycle c;
  - entry becomes a candidate in c+1;
  - issue_valid = 1 in c+2.
- **Wakeup-to-issue latency:** CDB match in cycle c gives issue_valid in c+2.
- **Sustained throughput:** 1 issue per cycle while issue_ready stays high and candidates exist.
- **Full condition:** DEPTH busy entries gives rs_ready = 0 and rs_index = 0. A slot load at edge e makes rs_ready = 1 in cycle e+1.
- **Reset mid-operation:** asynchronous; all outputs return to their reset values immediately, independent of clk.

## Test plan

- **Basic issue:** reset, then dispatch reorder=5 with both operands ready (0x11, 0x22), issue_ready=1 → issue_valid high exactly 2 cycles later with operand {0x11,0x22} and reorder 5; occupancy goes 0→1→0.
- **Age ordering:** dispatch tags 1, 2, 3 back-to-back, each waiting on tag 9, with issue_ready=1; broadcast cdb tag 9 data 0xAB on port 0 → issues in order 1, 2, 3 on consecutive cycles, each with operand value 0xAB.
- **Same-cycle wakeup and dispatch:** dispatch waiting on tag 7 while cdb port 1 broadcasts tag 7 data 0x55 in the same cycle → issue_valid 2 cycles later with operand 0x55.
- **Backpressure and full:** hold issue_ready=0 and dispatch DEPTH+1 ready ops → rs_ready=0 once DEPTH entries are busy; the slot stays stable. Raise issue_ready for one cycle → exactly one issue, then rs_ready=1 the following cycle, with rs_index equal to the freed entry.
- **Flush:** 3 busy entries plus a valid slot, assert flush → next cycle issue_valid=0, occupancy=0, rs_index=0, and a dispatch presented during the flush cycle is dropped.
- **Async reset:** assert rst between clock edges while issue_valid=1 → issue_valid=0 immediately.
